// File: rtl/riscv_pkg.sv
// riscv_pkg: shared branch encodings, PC-unit FSM states and reset/trap vectors
package riscv_pkg;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC_DEF = 32'h0000_0100;
  typedef enum logic [1:0] {RUN, FLUSH, TRAP} pc_state_t;
endpackage

// File: rtl/branch_taken_sel.sv
// branch_taken_sel: picks the comparator flag named by funct3; other flags are ignored
module branch_taken_sel
  import riscv_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       BrEq,
  input  logic       Bne,
  input  logic       BrLT,
  input  logic       Bge,
  input  logic       Bltu,
  input  logic       Bgeu,
  output logic       taken
);
  // funct3 010/011 are not branch encodings and fall through to not-taken
  always_comb begin
    taken = funct3 == F3_BEQ  ? BrEq :
            funct3 == F3_BNE  ? Bne  :
            funct3 == F3_BLT  ? BrLT :
            funct3 == F3_BGE  ? Bge  :
            funct3 == F3_BLTU ? Bltu :
            funct3 == F3_BGEU ? Bgeu : 1'b0;
  end
endmodule

// File: rtl/branch_pc_unit.sv
// branch_pc_unit: fetch PC sequencer with branch/jump redirect, flush window and misaligned-target trap
module branch_pc_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = RESET_PC_DEF,
  parameter logic [31:0] TRAP_VEC     = TRAP_VEC_DEF,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_valid,
  input  logic        jal,
  input  logic        jalr,
  input  logic [2:0]  funct3,
  input  logic        BrEq,
  input  logic        Bne,
  input  logic        BrLT,
  input  logic        Bge,
  input  logic        Bltu,
  input  logic        Bgeu,
  input  logic [31:0] ex_pc,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        PCSel,
  output logic        flush,
  output logic        misalign,
  output logic [15:0] redirect_cnt
);
  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);
  pc_state_t   state_q;
  logic [31:0] pc_q;
  logic [2:0]  fcnt_q;
  logic [15:0] cnt_q;
  logic        pcsel_q, flush_q, misalign_q;
  logic        taken, redir;
  logic [31:0] jalr_sum, target;
  branch_taken_sel u_sel (
    .funct3(funct3),
    .BrEq  (BrEq),
    .Bne   (Bne),
    .BrLT  (BrLT),
    .Bge   (Bge),
    .Bltu  (Bltu),
    .Bgeu  (Bgeu),
    .taken (taken)
  );
  // jalr wins over jal, jal over a taken branch; JALR drops bit 0 of its sum
  always_comb begin
    jalr_sum = rs1 + imm;
    redir    = jalr | jal | (br_valid & taken);
    target   = jalr ? {jalr_sum[31:1], 1'b0} : ex_pc + imm;
  end
  // RUN advances or redirects; TRAP is a one-cycle misalign pulse; FLUSH kills IF/ID for FLUSH_CYCLES
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      fcnt_q     <= '0;
      cnt_q      <= '0;
      pcsel_q    <= 1'b0;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else if (stall) begin
      pcsel_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pcsel_q    <= 1'b0;
      misalign_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (!redir) begin
            pc_q <= pc_q + 32'd4;
          end else if (target[1]) begin
            pc_q       <= TRAP_VEC;
            pcsel_q    <= 1'b1;
            misalign_q <= 1'b1;
            state_q    <= TRAP;
          end else begin
            pc_q    <= target;
            pcsel_q <= 1'b1;
            flush_q <= 1'b1;
            fcnt_q  <= FLUSH_LAST;
            cnt_q   <= cnt_q + 16'd1;
            state_q <= FLUSH;
          end
        end
        TRAP: begin
          pc_q    <= pc_q + 32'd4;
          flush_q <= 1'b1;
          fcnt_q  <= FLUSH_LAST;
          state_q <= FLUSH;
        end
        default: begin
          pc_q <= pc_q + 32'd4;
          if (fcnt_q == 3'd0) begin
            flush_q <= 1'b0;
            state_q <= RUN;
          end else begin
            fcnt_q <= fcnt_q - 3'd1;
          end
        end
      endcase
    end
  end
  assign pc           = pc_q;
  assign pc_plus4     = pc_q + 32'd4;
  assign PCSel        = pcsel_q;
  assign flush        = flush_q;
  assign misalign     = misalign_q;
  assign redirect_cnt = cnt_q;
endmodule

// File: doc/branch_pc_unit.md
BRANCH_PC_UNIT -- requirements
Module: branch_pc_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL have parameter TRAP_VEC, default 32'h0000_0100, PC loaded on misaligned target.
REQ-003 SHALL have parameter FLUSH_CYCLES, default 2, number of cycles flush stays high after a redirect (legal range 1..7).
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port stall, input, 1, freezes all state when high.
REQ-007 SHALL have ports br_valid, jal, jalr, input, 1 each, meaning execute-stage branch, JAL, or JALR valid.
REQ-008 SHALL have port funct3, input, 3, branch type of the execute-stage instruction.
REQ-009 SHALL have ports BrEq, Bne, BrLT, Bge, Bltu, Bgeu, input, 1 each, flags from the branch comparator stage.
REQ-010 SHALL have ports ex_pc, imm, rs1, input, 32 each, meaning execute-stage PC, immediate, and JALR base.
REQ-011 SHALL have ports pc and pc_plus4, output, 32 each, meaning fetch PC and fetch PC + 4.
REQ-012 SHALL have ports PCSel, flush, misalign, output, 1 each, meaning redirect pulse, IF/ID kill, and target-misaligned trap pulse.
REQ-013 SHALL have port redirect_cnt, output, 16, count of taken redirects.

Function
REQ-014 SHALL select taken per funct3: 000 BrEq, 001 Bne, 100 BrLT, 101 Bge, 110 Bltu, 111 Bgeu; 010 and 011 are never taken.
REQ-015 SHALL sample only the flag selected by funct3 and ignore all other flags.
REQ-016 SHALL compute the branch/JAL target as ex_pc+imm, and the JALR target as (rs1+imm) with bit 0 cleared, both modulo 2^32.
REQ-017 SHALL use redirect priority jalr > jal > (br_valid and taken) when several request inputs are high.
REQ-018 SHALL implement an FSM with states RUN, FLUSH, TRAP.
REQ-019 SHALL behave as follows in RUN with stall=0 and no redirect: pc <= pc+4, wrapping 32'hFFFF_FFFC to 32'h0000_0000.
REQ-020 SHALL behave as follows in RUN with stall=0, a redirect, and target[1]=0: pc <= target, redirect_cnt +1, next state FLUSH.
REQ-021 SHALL behave as follows in RUN with stall=0, a redirect, and target[1]=1: pc <= TRAP_VEC, redirect_cnt unchanged, next state TRAP.
REQ-022 SHALL hold misalign high for exactly one cycle in TRAP, then enter FLUSH.
REQ-023 SHALL keep flush high for FLUSH_CYCLES cycles in FLUSH, ignore all redirect requests, increment pc by 4 each cycle, then return to RUN.
REQ-024 SHALL make every output registered, with latency 1: a redirect decided in cycle N makes PCSel high and flush high from cycle N+1.
REQ-025 SHALL make PCSel a single-cycle pulse per redirect, including a trap redirect.
REQ-026 SHALL, when stall=1 in any state, hold pc, the state, the flush counter, and redirect_cnt, and evaluate no redirect; PCSel and misalign are low during stall.
REQ-027 SHALL always drive pc_plus4 equal to pc+4 modulo 2^32.
REQ-028 SHALL wrap redirect_cnt from 16'hFFFF to 16'h0000.

Reset
REQ-029 SHALL, when rst=1 at a clock edge, set pc=RESET_PC, pc_plus4=RESET_PC+4, PCSel=0, flush=0, misalign=0, redirect_cnt=0, state=RUN.
REQ-030 SHALL give rst priority over stall and all redirect inputs.
REQ-031 SHALL abort any FLUSH or TRAP sequence in progress when reset is asserted mid-sequence.

Structure
REQ-032 SHALL take the funct3 branch encodings, the FSM state encoding, and the RESET_PC and TRAP_VEC defaults from shared package riscv_pkg.
REQ-033 SHALL place the funct3 flag-select logic in one combinational sub-module, branch_taken_sel.

Verification
REQ-034 SHALL cover reset then 3 free-running cycles -> pc = 0, 4, 8, 12; PCSel=0, flush=0.
REQ-035 SHALL cover ex_pc=0x40, imm=0x20, br_valid=1, funct3=000, BrEq=1 -> next cycle pc=0x60, PCSel=1 for 1 cycle, flush=1 for 2 cycles, redirect_cnt=1.
REQ-036 SHALL cover funct3=001, Bne=0, BrEq=1 -> not taken; pc increments by 4; redirect_cnt unchanged.
REQ-037 SHALL cover jalr=1, rs1=0x103, imm=0 -> pc=0x102 is misaligned, so pc=0x100, misalign pulses 1 cycle, flush follows; also jalr=1, rs1=0x101 -> pc=0x100, no trap.
REQ-038 SHALL cover a redirect request during FLUSH, then stall=1 for 3 cycles -> request ignored; pc, flush count, and state frozen during stall.
REQ-039 SHALL cover pc=0xFFFF_FFFC running free -> pc wraps to 0x0; and rst asserted during FLUSH -> flush=0 and pc=RESET_PC the next cycle.
